// File: rtl/instr_encoder.sv
// instr_encoder: accepts one symbolic MIPS instruction per valid/ready handshake,
// encodes it into a 32-bit word and writes it to the next instruction-memory slot.
// beq offsets are derived from the encoder's own write-address counter.
// The beq offset is sign-extended to 16 bits, so ADDR_WIDTH must be 14 or less.
module instr_encoder #(
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            op_sel,
    input  logic [4:0]            rs,
    input  logic [4:0]            rt,
    input  logic [4:0]            rd,
    input  logic [15:0]           imm,
    input  logic [25:0]           target,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  err
);

    typedef enum logic [1:0] {StIdle, StEnc, StWrite, StFull} state_t;

    state_t                r_state;
    logic [3:0]            r_op;
    logic [4:0]            r_rs;
    logic [4:0]            r_rt;
    logic [4:0]            r_rd;
    logic [15:0]           r_imm;
    logic [25:0]           r_target;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH:0]   r_count;
    logic [31:0]           r_wdata;
    logic                  r_err;

    logic [ADDR_WIDTH:0]   w_off;
    logic [15:0]           w_off16;
    logic [31:0]           w_word;
    logic                  w_legal;

    // beq offset: destination minus the next sequential address, one bit wider than the
    // address so every in-range difference is representable, then sign-extended.
    assign w_off   = {1'b0, r_target[ADDR_WIDTH-1:0]}
                   - ({1'b0, r_addr} + {{ADDR_WIDTH{1'b0}}, 1'b1});
    assign w_off16 = {{(15 - ADDR_WIDTH){w_off[ADDR_WIDTH]}}, w_off};

    // Encode the captured instruction; op_sel 10..15 is flagged illegal.
    always_comb begin
        w_legal = 1'b1;
        w_word  = 32'h0;
        case (r_op)
            4'd0:    w_word = {6'h00, r_rs, r_rt, r_rd, 5'd0, 6'h20};
            4'd1:    w_word = {6'h00, r_rs, r_rt, r_rd, 5'd0, 6'h22};
            4'd2:    w_word = {6'h00, r_rs, r_rt, r_rd, 5'd0, 6'h24};
            4'd3:    w_word = {6'h00, r_rs, r_rt, r_rd, 5'd0, 6'h25};
            4'd4:    w_word = {6'h00, r_rs, r_rt, r_rd, 5'd0, 6'h2A};
            4'd5:    w_word = {6'h23, r_rs, r_rt, r_imm};
            4'd6:    w_word = {6'h2B, r_rs, r_rt, r_imm};
            4'd7:    w_word = {6'h08, r_rs, r_rt, r_imm};
            4'd8:    w_word = {6'h04, r_rs, r_rt, w_off16};
            4'd9:    w_word = {6'h02, r_target};
            default: w_legal = 1'b0;
        endcase
    end

    // Control FSM with address counter, word count, encoded-word register and sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= StIdle;
            r_op     <= 4'd0;
            r_rs     <= 5'd0;
            r_rt     <= 5'd0;
            r_rd     <= 5'd0;
            r_imm    <= 16'h0;
            r_target <= 26'h0;
            r_addr   <= '0;
            r_count  <= '0;
            r_wdata  <= 32'h0;
            r_err    <= 1'b0;
        end else if (clear) begin
            // Restart wins over any state and over a coincident handshake.
            r_state <= StIdle;
            r_addr  <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (in_valid) begin
                        r_op     <= op_sel;
                        r_rs     <= rs;
                        r_rt     <= rt;
                        r_rd     <= rd;
                        r_imm    <= imm;
                        r_target <= target;
                        r_state  <= StEnc;
                    end
                end
                StEnc: begin
                    if (w_legal) begin
                        r_wdata <= w_word;
                        r_state <= StWrite;
                    end else begin
                        r_err   <= 1'b1;
                        r_state <= StIdle;
                    end
                end
                StWrite: begin
                    r_addr  <= r_addr + 1'b1;
                    r_count <= r_count + 1'b1;
                    r_state <= (r_addr == {ADDR_WIDTH{1'b1}}) ? StFull : StIdle;
                end
                StFull: r_state <= StFull;
                default: r_state <= StIdle;
            endcase
        end
    end

    // clear gates the strobe and ready combinationally so an abort takes effect in the same cycle.
    assign in_ready   = (r_state == StIdle) & ~clear;
    assign imem_we    = (r_state == StWrite) & ~clear;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign count      = r_count;
    assign full       = (r_state == StFull);
    assign err        = r_err;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: expected (address, word) pairs are queued when an
// instruction is handed over and popped by a monitor whenever the DUT strobes imem_we.
module tb_instr_encoder;

    localparam int AW = 3;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   word;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clear = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [3:0]    op_sel = 4'd0;
    logic [4:0]    rs = 5'd0, rt = 5'd0, rd = 5'd0;
    logic [15:0]   imm = 16'h0;
    logic [25:0]   target = 26'h0;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic [AW:0]   count;
    logic          full;
    logic          err;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   m_addr = 0;

    instr_encoder #(.ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op_sel     (op_sel),
        .rs         (rs),
        .rt         (rt),
        .rd         (rd),
        .imm        (imm),
        .target     (target),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .count      (count),
        .full       (full),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference encoding written straight from the opcode/funct table.
    function automatic logic [31:0] enc(input logic [3:0] op, input logic [4:0] s, t, d,
                                        input logic [15:0] im, input logic [25:0] tg,
                                        input int addr);
        logic [15:0] off;
        off = 16'(int'(tg[AW-1:0]) - (addr + 1));
        case (op)
            4'd0: return {6'h00, s, t, d, 5'd0, 6'h20};
            4'd1: return {6'h00, s, t, d, 5'd0, 6'h22};
            4'd2: return {6'h00, s, t, d, 5'd0, 6'h24};
            4'd3: return {6'h00, s, t, d, 5'd0, 6'h25};
            4'd4: return {6'h00, s, t, d, 5'd0, 6'h2A};
            4'd5: return {6'h23, s, t, im};
            4'd6: return {6'h2B, s, t, im};
            4'd7: return {6'h08, s, t, im};
            4'd8: return {6'h04, s, t, off};
            default: return {6'h02, tg};
        endcase
    endfunction

    // Hand one instruction over; returns #1 after the transfer edge (i.e. in the ENC cycle).
    // use_want selects a literal expected word instead of the model's.
    task automatic send(input logic [3:0] op, input logic [4:0] s, t, d, input logic [15:0] im,
                        input logic [25:0] tg, input bit expect_wr, input bit use_want,
                        input logic [31:0] want);
        exp_t e;
        int   w;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 40) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) check("ready_timeout", 32'(in_ready), 32'd1);
        op_sel = op; rs = s; rt = t; rd = d; imm = im; target = tg;
        if (expect_wr && op <= 4'd9) begin
            e.addr = AW'(m_addr);
            e.word = use_want ? want : enc(op, s, t, d, im, tg, m_addr);
            sb_q.push_back(e);
            m_addr = (m_addr + 1) % (1 << AW);
        end
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Monitor: every write strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && imem_we) begin
            if (sb_q.size() == 0) begin
                check("spurious_we", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("we_addr", 32'(imem_addr), 32'(e.addr));
                check("we_data", imem_wdata, e.word);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  r_op;
        logic [25:0] r_tg;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_we", 32'(imem_we), 32'd0);
        check("rst_addr", 32'(imem_addr), 32'd0);
        check("rst_wdata", imem_wdata, 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_err", 32'(err), 32'd0);

        // R-type add with cycle-accurate latency/throughput checks.
        send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b1, 1'b1, 32'h00221820);
        @(negedge clk);
        check("enc_ready", 32'(in_ready), 32'd0);
        check("enc_we", 32'(imem_we), 32'd0);
        @(negedge clk);
        check("wr_we", 32'(imem_we), 32'd1);
        check("wr_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("n3_ready", 32'(in_ready), 32'd1);
        check("n3_count", 32'(count), 32'd1);

        // lw, pre-fill, then beq backward to 3 from address 5.
        send(4'd5, 5'd9, 5'd8, 5'd0, 16'd4, 26'h0, 1'b1, 1'b1, 32'h8D280004);
        send(4'd1, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0, 1'b1, 1'b0, 32'h0);
        send(4'd2, 5'd7, 5'd8, 5'd9, 16'h0, 26'h0, 1'b1, 1'b0, 32'h0);
        send(4'd6, 5'd10, 5'd11, 5'd0, 16'hFFF0, 26'h0, 1'b1, 1'b0, 32'h0);
        send(4'd8, 5'd1, 5'd2, 5'd31, 16'h1234, 26'd3, 1'b1, 1'b1, 32'h1022FFFD);

        // Illegal op: nothing written, err rises two cycles after the handshake.
        send(4'd12, 5'd1, 5'd1, 5'd1, 16'h1, 26'h1, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check("ill_err_n1", 32'(err), 32'd0);
        @(negedge clk);
        check("ill_err_n2", 32'(err), 32'd1);
        check("ill_ready_n2", 32'(in_ready), 32'd1);
        check("ill_count", 32'(count), 32'd6);

        // j at 6, addi at 7 fills the memory.
        send(4'd9, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10, 1'b1, 1'b1, 32'h08000010);
        send(4'd7, 5'd3, 5'd4, 5'd5, 16'h8001, 26'h0, 1'b1, 1'b0, 32'h0);
        repeat (3) @(negedge clk);
        check("fill_full", 32'(full), 32'd1);
        check("fill_ready", 32'(in_ready), 32'd0);
        check("fill_count", 32'(count), 32'd8);
        check("fill_err_sticky", 32'(err), 32'd1);

        // Extra request while full must be ignored.
        op_sel = 4'd0;
        in_valid = 1'b1;
        repeat (5) @(negedge clk);
        in_valid = 1'b0;
        check("full_hold_count", 32'(count), 32'd8);
        check("full_hold_full", 32'(full), 32'd1);

        // clear restarts everything.
        clear = 1'b1;
        #1 check("clr_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1 clear = 1'b0;
        m_addr = 0;
        check("clr_full", 32'(full), 32'd0);
        check("clr_count", 32'(count), 32'd0);
        check("clr_err", 32'(err), 32'd0);
        check("clr_addr", 32'(imem_addr), 32'd0);

        // clear during ENC aborts; the next write still lands at 0.
        send(4'd0, 5'd2, 5'd2, 5'd2, 16'h0, 26'h0, 1'b0, 1'b0, 32'h0);
        clear = 1'b1;
        @(negedge clk);
        check("abort_enc_we", 32'(imem_we), 32'd0);
        @(posedge clk);
        #1 clear = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_enc_count", 32'(count), 32'd0);
        send(4'd3, 5'd6, 5'd7, 5'd8, 16'h0, 26'h0, 1'b1, 1'b0, 32'h0);

        // Random legal instructions against the model (addresses 1..6).
        for (int i = 0; i < 6; i++) begin
            r_op = 4'($urandom_range(0, 9));
            r_tg = 26'($urandom);
            send(r_op, 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), r_tg,
                 1'b1, 1'b0, 32'h0);
        end
        repeat (3) @(negedge clk);
        check("rand_count", 32'(count), 32'd7);

        // rst during WRITE drops the strobe immediately.
        send(4'd4, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0, 1'b0, 32'h0);
        @(posedge clk);
        #1 check("pre_rst_we", 32'(imem_we), 32'd1);
        rst = 1'b1;
        #1;
        check("arst_we", 32'(imem_we), 32'd0);
        check("arst_ready", 32'(in_ready), 32'd1);
        check("arst_addr", 32'(imem_addr), 32'd0);
        check("arst_wdata", imem_wdata, 32'd0);
        check("arst_count", 32'(count), 32'd0);
        check("arst_full", 32'(full), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        m_addr = 0;
        send(4'd0, 5'd5, 5'd6, 5'd7, 16'h0, 26'h0, 1'b1, 1'b0, 32'h0);
        repeat (4) @(negedge clk);
        check("final_count", 32'(count), 32'd1);
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
